// File: rtl/mu0_reg12.sv
// rtl/mu0_reg12.sv - 12-bit load-enabled register for the MU0 datapath
//
// Purpose: general-purpose storage register (ACC, PC, IR). Captures D on the
// rising Clk edge when En is high, holds otherwise, and clears to RESET_VALUE
// on a synchronous active-high Reset. Q comes straight from the flops.
//
// Ports (positional order is fixed: Clk, Reset, En, D, Q):
//   Clk    in   1      system clock, rising-edge active
//   Reset  in   1      synchronous active-high reset, overrides En
//   En     in   1      load enable, active-high
//   D      in   WIDTH  data to load
//   Q      out  WIDTH  registered contents
//
// Optional macro MU0_REG12_CHECK_EN: compiles in simulation-only X/Z and
// reset-value checks. The synthesized logic is the same either way.

module mu0_reg12 #(
    parameter int              WIDTH       = 12,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Hold mux rather than a gated clock: the flop reloads its own value
    // when the enable is low.
    always_comb begin
        q_d = q_q;
        if (En) begin
            q_d = D;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

`ifdef MU0_REG12_CHECK_EN
    // Remembers whether the last rising edge sampled Reset high, so Q can be
    // inspected half a cycle later once the flops have settled.
    logic chk_rst_q;

    always @(posedge Clk) begin
        if ($isunknown(Reset)) begin
            $error("mu0_reg12: Reset is X/Z at rising edge");
        end
        if ($isunknown(En)) begin
            $error("mu0_reg12: En is X/Z at rising edge");
        end
        if (En === 1'b1 && Reset === 1'b0 && $isunknown(D)) begin
            $error("mu0_reg12: D is X/Z while loading");
        end
        chk_rst_q <= (Reset === 1'b1);
    end

    always @(negedge Clk) begin
        if (chk_rst_q && (Q !== RESET_VALUE)) begin
            $error("mu0_reg12: Q=%h after reset, expected %h", Q, RESET_VALUE);
        end
    end
`endif

endmodule

// File: tb/tb_mu0_reg12.sv
// tb/tb_mu0_reg12.sv - directed self-checking bench for mu0_reg12

module tb_mu0_reg12;

    logic        Clk;
    logic        Reset;
    logic        En;
    logic [11:0] D;
    logic [11:0] Q;

    int checks = 0;
    int errors = 0;

    mu0_reg12 dut (
        .Clk   (Clk),
        .Reset (Reset),
        .En    (En),
        .D     (D),
        .Q     (Q)
    );

    // 100 ns period; rising edges at 50, 150, 250, ...
    initial Clk = 1'b0;
    always #50 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [11:0] pat;
        logic [11:0] prev;

        // Reset held for two edges with En=1 and D=FFE: D must not load.
        Reset = 1'b1;
        En    = 1'b1;
        D     = 12'hFFE;
        step();
        check_eq("reset_edge1", Q, 12'h000);
        step();
        check_eq("reset_edge2", Q, 12'h000);

        // Plain load.
        Reset = 1'b0;
        step();
        check_eq("load_ffe", Q, 12'hFFE);

        // Hold for two edges with a new D present.
        En = 1'b0;
        D  = 12'hFFA;
        step();
        check_eq("hold_edge1", Q, 12'hFFE);
        step();
        check_eq("hold_edge2", Q, 12'hFFE);

        // Re-enable.
        En = 1'b1;
        step();
        check_eq("load_ffa", Q, 12'hFFA);

        // Mid-cycle reset pulse: rises 25 ns after an edge, lasts 125 ns.
        #24;
        Reset = 1'b1;
        #25;
        check_eq("midrst_before_edge", Q, 12'hFFA);
        @(posedge Clk);
        #1;
        check_eq("midrst_after_edge", Q, 12'h000);
        #49;
        Reset = 1'b0;
        #10;
        check_eq("midrst_fall_no_effect", Q, 12'h000);
        step();
        check_eq("midrst_reload", Q, 12'hFFA);

        // Reset dominates a deasserted enable.
        En    = 1'b0;
        Reset = 1'b1;
        step();
        check_eq("rst_over_en0", Q, 12'h000);

        // Back-to-back loads alternating 555/AAA; Q follows one edge later.
        Reset = 1'b0;
        En    = 1'b1;
        prev  = 12'h000;
        for (int i = 0; i < 6; i++) begin
            pat = (i % 2 == 0) ? 12'h555 : 12'hAAA;
            D   = pat;
            #40;
            check_eq("b2b_before_edge", Q, prev);
            @(posedge Clk);
            #1;
            check_eq("b2b_after_edge", Q, pat);
            prev = pat;
        end

        // Load a known value, then glitch D between edges.
        D = 12'h123;
        step();
        check_eq("glitch_setup", Q, 12'h123);
        D = 12'hFFF;
        #10;
        D = 12'h000;
        #10;
        D = 12'hABC;
        #10;
        check_eq("glitch_d_midcycle", Q, 12'h123);
        D = 12'h456;
        step();
        check_eq("glitch_d_settled_load", Q, 12'h456);

        // En glitch between edges while disabled: no load at the next edge.
        En = 1'b0;
        D  = 12'h789;
        #20;
        En = 1'b1;
        #10;
        En = 1'b0;
        #10;
        check_eq("glitch_en_midcycle", Q, 12'h456);
        step();
        check_eq("glitch_en_no_load", Q, 12'h456);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
